// File: rtl/mole_round_ctrl_pkg.sv
// Shared definitions for the whack-a-mole round controller.
//  - state_t     : round sequencer states
//  - LFSR_SEED   : LFSR value loaded on reset
//  - LFSR_TAPS   : feedback mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//  - SCORE_W / MISS_W : score and miss counter widths
//  - pick_idx()  : mole index selection that never repeats the previous mole
package mole_round_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM0 = 3'd1,
        ST_ARM1 = 3'd2,
        ST_SHOW = 3'd3,
        ST_HIT  = 3'd4,
        ST_MISS = 3'd5,
        ST_OVER = 3'd6
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam int         SCORE_W   = 8;
    localparam int         MISS_W    = 4;

    // idx = rnd % n, bumped by one (mod n) if it would repeat prev.
    function automatic logic [2:0] pick_idx(input logic [7:0] rnd,
                                            input logic [2:0] prev,
                                            input int         n);
        int r;
        r = int'(rnd) % n;
        if (r == int'(prev))
            r = (r + 1) % n;
        return 3'(r);
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), shifting left every
// cycle and reseeded while rst_n is low.
//  clk   in   master clock
//  rst_n in   synchronous active-low reset (loads LFSR_SEED)
//  value out  raw 8-bit LFSR state
module mole_lfsr
    import mole_round_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] value
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            value <= LFSR_SEED;
        else
            value <= {value[6:0], ^(value & LFSR_TAPS)};
    end

endmodule

// File: rtl/mole_round_ctrl.sv
// Game-round sequencer sitting in front of interval_counter. Each round picks a
// mole from the LFSR, holds the counter in reload for two cycles, lights the
// mole and waits for a hit, a wrong press or a timeout edge. Keeps score,
// misses and game-over state, and shortens the interval as the score rises.
//  clk, rst_n  clock, synchronous active-low reset
//  start       level, sampled in IDLE and OVER
//  btn         debounced active-high buttons, one per mole
//  timeout     counter timeout level (rising edge used)
//  ctr_rst_n   counter reset/reload, high only while a mole is shown
//  interval    seconds for the current round
//  dir         constant count direction
//  mole        one-hot lit mole, 0 when none
//  hit_pulse   one cycle on a correct hit
//  miss_pulse  one cycle on a timeout or wrong press
//  score       saturating hit count
//  misses      miss count
//  game_over   high in OVER
module mole_round_ctrl
    import mole_round_ctrl_pkg::*;
#(
    parameter int NUM_MOLES      = 4,
    parameter int INIT_INTERVAL  = 5,
    parameter int MIN_INTERVAL   = 1,
    parameter int HITS_PER_LEVEL = 4,
    parameter int MAX_MISSES     = 3,
    parameter bit COUNT_DIR      = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] btn,
    input  logic                 timeout,
    output logic                 ctr_rst_n,
    output logic [2:0]           interval,
    output logic                 dir,
    output logic [NUM_MOLES-1:0] mole,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic [SCORE_W-1:0]   score,
    output logic [MISS_W-1:0]    misses,
    output logic                 game_over
);

    localparam logic [2:0]         INIT_IV = 3'(INIT_INTERVAL);
    localparam logic [2:0]         MIN_IV  = 3'(MIN_INTERVAL);
    localparam logic [MISS_W-1:0]  MAX_MS  = MISS_W'(MAX_MISSES);
    localparam logic [SCORE_W-1:0] HPL     = SCORE_W'(HITS_PER_LEVEL);

    state_t                 state, state_nx;
    logic [7:0]             lfsr;
    logic [2:0]             prev_idx;
    logic [NUM_MOLES-1:0]   btn_q;
    logic                   to_q;
    logic [NUM_MOLES-1:0]   rise_btn;
    logic                   to_edge;
    logic [NUM_MOLES-1:0]   mole_lit;
    logic [SCORE_W-1:0]     score_inc;
    logic                   level_up;

    mole_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (lfsr)
    );

    assign dir       = COUNT_DIR;
    assign rise_btn  = btn & ~btn_q;
    assign to_edge   = timeout & ~to_q;
    // prev_idx is latched in ARM0, so during SHOW it holds the current mole.
    assign mole_lit  = NUM_MOLES'(1) << prev_idx;
    assign score_inc = (score == '1) ? score : score + 1'b1;
    assign level_up  = ((score_inc % HPL) == '0) && (interval > MIN_IV);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        ctr_rst_n  = 1'b0;
        mole       = '0;
        hit_pulse  = 1'b0;
        miss_pulse = 1'b0;
        game_over  = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nx = ST_ARM0;
            ST_ARM0: state_nx = ST_ARM1;
            ST_ARM1: state_nx = ST_SHOW;
            ST_SHOW: begin
                ctr_rst_n = 1'b1;
                mole      = mole_lit;
                // Any press decides the round; a correct press beats a same-cycle timeout.
                if (rise_btn != '0)
                    state_nx = (rise_btn == mole_lit) ? ST_HIT : ST_MISS;
                else if (to_edge)
                    state_nx = ST_MISS;
            end
            ST_HIT: begin
                hit_pulse = 1'b1;
                state_nx  = ST_ARM0;
            end
            ST_MISS: begin
                miss_pulse = 1'b1;
                state_nx   = (misses >= MAX_MS) ? ST_OVER : ST_ARM0;
            end
            ST_OVER: begin
                game_over = 1'b1;
                if (start) state_nx = ST_ARM0;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            interval <= INIT_IV;
            score    <= '0;
            misses   <= '0;
            prev_idx <= '0;
            btn_q    <= '1;
            to_q     <= 1'b1;
        end else begin
            btn_q <= btn;
            // Counter is reloading during ARM; a timeout still high from the
            // last round must not look like a fresh edge once SHOW begins.
            to_q  <= (state == ST_ARM0 || state == ST_ARM1) ? 1'b1 : timeout;
            if (state == ST_ARM0)
                prev_idx <= pick_idx(lfsr, prev_idx, NUM_MOLES);
            if ((state == ST_IDLE || state == ST_OVER) && start) begin
                score    <= '0;
                misses   <= '0;
                interval <= INIT_IV;
            end
            if (state == ST_SHOW && state_nx == ST_HIT) begin
                score <= score_inc;
                if (level_up)
                    interval <= interval - 3'd1;
            end
            if (state == ST_SHOW && state_nx == ST_MISS)
                misses <= misses + 1'b1;
        end
    end

endmodule

// File: tb/tb_mole_round_ctrl.sv
module tb_mole_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, timeout;
    logic [3:0] btn;
    logic       ctr_rst_n, dir, hit_pulse, miss_pulse, game_over;
    logic [2:0] interval;
    logic [3:0] mole, misses;
    logic [7:0] score;

    always #5 clk = ~clk;

    mole_round_ctrl #(
        .NUM_MOLES      (4),
        .INIT_INTERVAL  (5),
        .MIN_INTERVAL   (1),
        .HITS_PER_LEVEL (4),
        .MAX_MISSES     (3),
        .COUNT_DIR      (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .btn        (btn),
        .timeout    (timeout),
        .ctr_rst_n  (ctr_rst_n),
        .interval   (interval),
        .dir        (dir),
        .mole       (mole),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .score      (score),
        .misses     (misses),
        .game_over  (game_over)
    );

    typedef struct {
        logic       hit;
        logic [7:0] score;
        logic [3:0] misses;
        logic [2:0] interval;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         m_prev;
    logic [7:0] m_lfsr;
    logic [3:0] exp_mole, last_mole, m_misses;
    logic [7:0] m_score;
    logic [2:0] m_interval;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seeded with A5 while in reset.
    always @(posedge clk)
        m_lfsr <= !rst_n ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

    function automatic logic [3:0] rotl(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at the ARM0 sample point: the DUT picks from the LFSR value now present.
    task automatic arm_expect();
        int r;
        r = int'(m_lfsr) % 4;
        if (r == m_prev) r = (r + 1) % 4;
        m_prev    = r;
        last_mole = exp_mole;
        exp_mole  = 4'b0001 << r;
    endtask

    task automatic arm_show();
        chk("arm0_ctr_rst_n", ctr_rst_n, 0);
        chk("arm0_mole", mole, 0);
        arm_expect();
        tick();
        chk("arm1_ctr_rst_n", ctr_rst_n, 0);
        chk("arm1_mole", mole, 0);
        tick();
        chk("show_mole", mole, exp_mole);
        chk("show_ctr_rst_n", ctr_rst_n, 1);
        if (last_mole != 4'b0) chk("mole_changed", mole != last_mole, 1);
    endtask

    task automatic start_game();
        start = 1'b1;
        tick();
        start      = 1'b0;
        m_score    = 8'd0;
        m_misses   = 4'd0;
        m_interval = 3'd5;
        chk("start_score", score, 0);
        chk("start_misses", misses, 0);
        chk("start_interval", interval, 5);
        arm_show();
    endtask

    task automatic dwell(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("dwell_no_pulse", {hit_pulse, miss_pulse}, 0);
            chk("dwell_mole", mole, exp_mole);
        end
    endtask

    task automatic await_pulse();
        int   n = 1;
        exp_t e;
        while (!(hit_pulse || miss_pulse) && n < 4) begin
            tick();
            n++;
        end
        chk("pulse_latency", n, 1);
        chk("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pulse_hit", hit_pulse, e.hit);
            chk("pulse_miss", miss_pulse, !e.hit);
            chk("pulse_score", score, e.score);
            chk("pulse_misses", misses, e.misses);
            chk("pulse_interval", interval, e.interval);
            chk("pulse_mole_off", mole, 0);
        end
    endtask

    // Drive one cycle of buttons/timeout in SHOW, predict the outcome, check the pulse.
    task automatic act(input logic [3:0] b, input logic to, input logic exp_hit);
        exp_t e;
        if (exp_hit) begin
            if (m_score != 8'hFF) m_score = m_score + 8'd1;
            if ((m_score % 8'd4) == 8'd0 && m_interval > 3'd1) m_interval = m_interval - 3'd1;
        end else begin
            m_misses = m_misses + 4'd1;
        end
        e.hit      = exp_hit;
        e.score    = m_score;
        e.misses   = m_misses;
        e.interval = m_interval;
        sb.push_back(e);
        btn     = b;
        timeout = to;
        tick();
        btn     = 4'b0;
        timeout = 1'b0;
        await_pulse();
    endtask

    task automatic check_reset_outputs();
        chk("rst_ctr_rst_n", ctr_rst_n, 0);
        chk("rst_interval", interval, 5);
        chk("rst_mole", mole, 0);
        chk("rst_score", score, 0);
        chk("rst_misses", misses, 0);
        chk("rst_pulses", {hit_pulse, miss_pulse}, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_dir", dir, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; btn = 4'b0; timeout = 1'b0;
        m_prev = 0; exp_mole = 4'b0; last_mole = 4'b0;
        m_score = 8'd0; m_misses = 4'd0; m_interval = 3'd5;
        tick();
        tick();
        check_reset_outputs();
        rst_n = 1'b1;
        tick();
        chk("idle_ctr_rst_n", ctr_rst_n, 0);
        chk("idle_mole", mole, 0);

        // First round and a correct hit
        start_game();
        dwell(1);
        act(exp_mole, 1'b0, 1'b1);
        tick();
        arm_show();
        dwell(1);

        // Three timeouts end the game
        for (int i = 0; i < 3; i++) begin
            act(4'b0, 1'b1, 1'b0);
            tick();
            if (i < 2) begin
                arm_show();
                dwell(1);
            end
        end
        chk("over_game_over", game_over, 1);
        chk("over_ctr_rst_n", ctr_rst_n, 0);
        chk("over_mole", mole, 0);
        chk("over_score", score, 1);
        chk("over_misses", misses, 3);

        // Presses and timeouts in OVER are ignored
        btn = 4'b1111; timeout = 1'b1;
        tick();
        btn = 4'b0; timeout = 1'b0;
        chk("over_ignore_pulse", {hit_pulse, miss_pulse}, 0);
        chk("over_ignore_misses", misses, 3);
        chk("over_hold", game_over, 1);
        tick();

        // Restart, hit with same-cycle timeout edge, double press, wrong press
        start_game();
        dwell(1);
        act(exp_mole, 1'b1, 1'b1);
        tick();
        arm_show();
        dwell(1);
        act(exp_mole | rotl(exp_mole), 1'b0, 1'b0);
        tick();
        arm_show();
        dwell(1);
        act(rotl(exp_mole), 1'b0, 1'b0);

        // Timeout high through ARM into SHOW is not a miss; drop and re-raise is
        timeout = 1'b1;
        tick();
        arm_show();
        dwell(3);
        timeout = 1'b0;
        dwell(1);
        act(4'b0, 1'b1, 1'b0);
        tick();
        chk("over2_game_over", game_over, 1);
        chk("over2_misses", misses, 3);

        // Interval ladder, floor and score saturation
        start_game();
        dwell(1);
        for (int i = 0; i < 256; i++) begin
            act(exp_mole, 1'b0, 1'b1);
            if (i == 3)  chk("interval_after_4", interval, 4);
            if (i == 19) chk("interval_floor_20", interval, 1);
            tick();
            arm_show();
            dwell(1);
        end
        chk("score_saturated", score, 255);
        chk("interval_floor_end", interval, 1);

        // Reset mid-SHOW
        rst_n = 1'b0;
        tick();
        check_reset_outputs();
        rst_n    = 1'b1;
        m_prev   = 0;
        exp_mole = 4'b0;
        tick();
        start_game();
        dwell(1);
        act(exp_mole, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
